// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle 32-bit radix-2 restoring divider with EX stall request.
// Define DIV_SIGNED_EN to honour signed_div and build the sign fix-up logic.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  annul,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_from_ex
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   dvs;

  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   quo_nx;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg   = signed_div & opdata1[DATA_W-1];
  assign b_neg   = signed_div & opdata2[DATA_W-1];
  assign a_abs   = a_neg ? (~opdata1 + 1'b1) : opdata1;
  assign b_abs   = b_neg ? (~opdata2 + 1'b1) : opdata2;
  // -2^31 / -1 falls out naturally: magnitude 2^31 negates back to itself
  assign quo_fix = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign rem_fix = neg_r ? (~rem_nx + 1'b1) : rem_nx;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div;
  assign a_abs   = opdata1;
  assign b_abs   = opdata2;
  assign quo_fix = quo_nx;
  assign rem_fix = rem_nx;
`endif

  // One restoring step: trial-subtract the divisor from the shifted remainder
  assign diff   = {rem, quo[DATA_W-1]} - {1'b0, dvs};
  assign rem_nx = diff[DATA_W] ? {rem[DATA_W-2:0], quo[DATA_W-1]} : diff[DATA_W-1:0];
  assign quo_nx = {quo[DATA_W-2:0], ~diff[DATA_W]};

  assign stallreq_from_ex = ((state == S_FREE) & start & ~annul) |
                            (state == S_BYZERO) | (state == S_ON);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FREE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      result <= '0;
      ready  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (annul) begin
      state  <= S_FREE;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_FREE: begin
          if (start) begin
            cnt <= '0;
            rem <= '0;
            quo <= a_abs;
            dvs <= b_abs;
`ifdef DIV_SIGNED_EN
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
            state <= (opdata2 == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          result <= '0;
          ready  <= 1'b1;
          state  <= S_END;
        end
        S_ON: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            result <= {rem_fix, quo_fix};
            ready  <= 1'b1;
            state  <= S_END;
          end
        end
        S_END: begin
          if (!start) begin
            ready  <= 1'b0;
            result <= '0;
            state  <= S_FREE;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div.
// Expectations follow DIV_SIGNED_EN when the bench is built with it.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_from_ex;

  int total;
  int bad;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .annul            (annul),
    .signed_div       (signed_div),
    .opdata1          (opdata1),
    .opdata2          (opdata2),
    .result           (result),
    .ready            (ready),
    .stallreq_from_ex (stallreq_from_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one divide from a negedge; cycle 0 is the cycle start is first seen
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int cyc;
    int stl;
    bit done;
    @(negedge clk);
    start = 1'b1; signed_div = sg; opdata1 = a; opdata2 = b;
    cyc = 0; stl = 0; done = 1'b0;
    while (cyc < 100) begin
      #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
      if (stallreq_from_ex) stl++;
      @(negedge clk);
      cyc++;
      opdata1 = $urandom;
      opdata2 = $urandom;
    end
    chk({tag, ":done"}, 64'(done), 64'd1);
    chk({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, ":stall_cycles"}, 64'(stl), 64'(exp_lat));
    chk({tag, ":stall_at_ready"}, 64'(stallreq_from_ex), 64'd0);
    chk({tag, ":result"}, result, exp_res);
    @(negedge clk);
    #1;
    chk({tag, ":hold_ready"}, 64'(ready), 64'd1);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ":ready_clr"}, 64'(ready), 64'd0);
    chk({tag, ":result_clr"}, result, 64'd0);
  endtask

  initial begin
    bit seen;
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:result", result, 64'd0);
    chk("rst:ready", 64'(ready), 64'd0);
    chk("rst:stall", 64'(stallreq_from_ex), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    run_div("uffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
    run_div("uffff_16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);
    run_div("div0", 1'b0, 32'd5, 32'd0, 64'h0, 2);
    run_div("small_big", 1'b0, 32'd3, 32'd9, {32'h3, 32'h0}, 33);
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
`else
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 33);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h7, 32'h0}, 33);
`endif

    // annul in cycle 10 of ON
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    #1;
    chk("annul:stall_during", 64'(stallreq_from_ex), 64'd1);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul:stall_after", 64'(stallreq_from_ex), 64'd0);
    chk("annul:ready_after", 64'(ready), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready || stallreq_from_ex) seen = 1'b1;
    end
    chk("annul:no_ready", 64'(seen), 64'd0);

    // reset in cycle 15 of ON
    @(negedge clk);
    start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (15) @(negedge clk);
    #1;
    chk("rst_mid:stall_before", 64'(stallreq_from_ex), 64'd1);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_mid:ready", 64'(ready), 64'd0);
    chk("rst_mid:result", result, 64'd0);
    chk("rst_mid:stall", 64'(stallreq_from_ex), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit radix-2 restoring divider that sits beside the EX-stage ALU. It raises the EX stall request that feeds the pipeline stall controller, which freezes PC, IF/ID and ID/EX while EX/MEM and MEM/WB drain. It releases the request when the result is ready. It is the requesting end of the EX stall interface: it produces `stallreq_from_ex` and holds it for the whole division.

## Interface
- `DATA_W`, 32: operand width. Only 32 is supported.
- `CNT_W`, 6: iteration counter width. It must hold 0..32.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserted while `rst == 0`.
- `start` in 1: division request from EX decode. Held high by EX while it is stalled.
- `annul` in 1: cancel. A flush or exception kills the in-flight division.
- `signed_div` in 1: 1 = DIV, 0 = DIVU. Sampled with `start`.
- `opdata1` in 32: dividend. Sampled when `start` is accepted.
- `opdata2` in 32: divisor. Sampled when `start` is accepted.
- `result` out 64: {remainder[31:0], quotient[31:0]}. Registered.
- `ready` out 1: result valid. Registered.
- `stallreq_from_ex` out 1: stall request to the pipeline controller. Combinational from state and inputs.

## Operation
- States: FREE, BYZERO, ON, END.
- Reset: state = FREE, cnt = 0, `result` = 64'h0, `ready` = 0, internal registers = 0, so `stallreq_from_ex` = 0.
- FREE:
  - `start=1` and `annul=0`: latch the operand magnitudes and sign info.
  - Divisor == 0: go to BYZERO.
  - Otherwise: go to ON with cnt = 0, partial remainder = 0, quotient register = |dividend|.
- BYZERO: set result = 64'h0, go to END.
- ON, one iteration per cycle:
  - diff = {rem[31:0], q[31]} − {1'b0, |divisor|}, 33-bit.
  - diff[32] == 0: rem = diff[31:0], shift in quotient bit 1.
  - Otherwise: rem = {rem[30:0], q[31]}, shift in 0.
  - cnt++. At cnt == 31, go to END.
- END:
  - `result` and `ready` are loaded on entry. `ready` = 1.
  - Stay in END while `start` = 1.
  - `start` = 0: go to FREE, clearing `ready` and `result` to 0.
- Signed fix-up on entry to END:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - −2^31 / −1 gives quotient 32'h80000000 (wraps) and remainder 0.
- `annul` = 1 in any state: go to FREE next edge, with `ready` = 0 and `result` = 0. This has priority over every other transition.
- `stallreq_from_ex` = 1 when (FREE & `start` & !`annul`) | BYZERO | ON. It is 0 in END, so the controller releases the pipe in the same cycle `ready` is seen.

## Timing
- Cycle 0: `start` is sampled in FREE and `stallreq_from_ex` is already high (combinational).
- Normal divide: ON in cycles 1..32, END and `ready` in cycle 33. Stall high for cycles 0..32, 33 cycles total.
- Divide by zero: BYZERO in cycle 1, END in cycle 2. Stall high for cycles 0..1.
- Back-to-back divides need `start` low for at least one cycle (END→FREE).
- `rst` asserted mid-operation: outputs clear immediately and asynchronously, with no partial result.
- Operands are ignored after acceptance. Changes to `opdata*` during ON have no effect.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_div` is honoured and sign fix-up is performed.
- `DIV_SIGNED_EN` undefined: `signed_div` is ignored, all operands are treated as unsigned, and the fix-up logic is not built.

## Test plan
- 100 / 7 unsigned: `ready` in cycle 33, `result` = {32'h2, 32'hE}, stall high for cycles 0..32.
- −7 / 2 signed (`DIV_SIGNED_EN`): `result` = {32'hFFFFFFFF, 32'hFFFFFFFD}. Without the macro, the same operands give q = 32'h7FFFFFFC, r = 32'h1.
- 5 / 0: BYZERO path, `ready` in cycle 2, `result` = 64'h0.
- 32'h80000000 / 32'hFFFFFFFF signed: `result` = {32'h0, 32'h80000000}.
- `annul` pulsed in cycle 10 of ON: state FREE in cycle 11, `stallreq_from_ex` = 0 in cycle 11, `ready` never asserts.
- `rst` = 0 in cycle 15 of ON: `ready`, `result` and the stall clear immediately. After release, a new 100 / 7 completes normally in 33 cycles.
